// File: rtl/fact_arbiter.sv
// rtl/fact_arbiter.sv - round-robin sharing of one factorial core among NREQ requesters
// Optional BUSY watchdog enabled by defining FACT_ARB_TIMEOUT_EN.
module fact_arbiter #(
  parameter int NREQ       = 2,
  parameter int IW         = 4,
  parameter int DW         = 32,
  parameter int TMO_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*IW-1:0] req_n,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_result,
  output logic               rsp_err,
  output logic               core_go,
  output logic [IW-1:0]      core_n,
  input  logic               core_done,
  input  logic               core_err,
  input  logic [DW-1:0]      core_result
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, owner, win_idx;
  logic            win_found;
  logic            first_busy, done_q;
  logic            busy_done;
  logic            tmo_hit, tmo_flag;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % NREQ);
  endfunction

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[wrap_add(ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr, k);
      end
    end
  end

  // A done that was already high when BUSY began is stale and must not complete this op.
  assign busy_done = (state == BUSY) && core_done && !(first_busy && done_q);

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != BUSY) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == BUSY) && !busy_done && (tmo_cnt == CW'(TMO_CYCLES - 1));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (win_found) state_nxt = BUSY;
      BUSY:  if (busy_done || tmo_hit) state_nxt = RESP;
      RESP:  state_nxt = (tmo_flag || core_done) ? DRAIN : IDLE;
      DRAIN: if (!core_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      core_go    <= 1'b0;
      core_n     <= '0;
      ptr        <= PW'(NREQ - 1);
      owner      <= '0;
      first_busy <= 1'b0;
      done_q     <= 1'b0;
      tmo_flag   <= 1'b0;
    end else begin
      done_q    <= core_done;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt        <= ONE << win_idx;
            core_n     <= req_n[int'(win_idx)*IW +: IW];
            core_go    <= 1'b1;
            ptr        <= win_idx;
            owner      <= win_idx;
            first_busy <= 1'b1;
            tmo_flag   <= 1'b0;
          end
        end
        BUSY: begin
          first_busy <= 1'b0;
          if (busy_done) begin
            rsp_result <= core_err ? '0 : core_result;
            rsp_err    <= core_err;
            core_go    <= 1'b0;
            rsp_valid  <= ONE << owner;
          end else if (tmo_hit) begin
            rsp_result <= '1;
            rsp_err    <= 1'b1;
            core_go    <= 1'b0;
            rsp_valid  <= ONE << owner;
            tmo_flag   <= 1'b1;
          end
        end
        RESP: begin
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_arbiter.sv
// tb/tb_fact_arbiter.sv - directed self-checking bench for fact_arbiter
module tb_fact_arbiter;
  localparam int NREQ = 2;
  localparam int IW   = 4;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int LAT  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*IW-1:0] req_n;
  logic [NREQ-1:0]    gnt, rsp_valid;
  logic [DW-1:0]      rsp_result;
  logic               rsp_err, core_go;
  logic [IW-1:0]      core_n;
  logic               core_done, core_err;
  logic [DW-1:0]      core_result;

  int tests = 0;
  int fails = 0;
  bit core_hang = 1'b0;
  int core_cnt;

  fact_arbiter #(.NREQ(NREQ), .IW(IW), .DW(DW), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .core_go(core_go), .core_n(core_n),
    .core_done(core_done), .core_err(core_err), .core_result(core_result)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fact(input logic [IW-1:0] n);
    logic [DW-1:0] r;
    r = 1;
    for (int i = 2; i <= int'(n); i++) r = r * DW'(i);
    return r;
  endfunction

  // Core model: done (held) LAT+1 cycles after go rises, drops the cycle after go falls.
  always @(posedge clk) begin
    if (rst) begin
      core_done <= 1'b0; core_err <= 1'b0; core_result <= '0; core_cnt <= 0;
    end else if (core_go && !core_hang) begin
      if (core_cnt == LAT) begin
        core_done   <= 1'b1;
        core_err    <= (core_n > 4'd12);
        core_result <= (core_n > 4'd12) ? '0 : fact(core_n);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else begin
      core_done <= 1'b0;
      core_cnt  <= 0;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_rsp(output int idx, output int gap, output bit ok);
    int done_cyc;
    done_cyc = -1; ok = 1'b0; idx = -1; gap = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (core_done && done_cyc < 0) done_cyc = c;
      if (rsp_valid != '0) begin
        ok  = 1'b1;
        idx = (rsp_valid == 2'b01) ? 0 : (rsp_valid == 2'b10) ? 1 : -2;
        gap = c - done_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; req_n = '0;
    repeat (2) tick;
    tests++;
    if ({gnt, rsp_valid, core_go, core_n} !== '0) begin
      fails++; $display("FAIL reset_ctl: got %0h want 0", {gnt, rsp_valid, core_go, core_n});
    end
    tests++;
    if ({rsp_err, rsp_result} !== '0) begin
      fails++; $display("FAIL reset_rsp: got %0h want 0", {rsp_err, rsp_result});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int idx, gap; bit ok;
    req = 2'b01; req_n[3:0] = 4'd5;
    tick;
    tests++;
    if ({core_go, core_n, gnt} !== {1'b1, 4'd5, 2'b01}) begin
      fails++; $display("FAIL single_go: got go=%0b n=%0d gnt=%b want go=1 n=5 gnt=01", core_go, core_n, gnt);
    end
    wait_rsp(idx, gap, ok);
    tests++;
    if (!ok || idx != 0 || gap != 1) begin
      fails++; $display("FAIL single_rsp: got ok=%0b idx=%0d gap=%0d want ok=1 idx=0 gap=1", ok, idx, gap);
    end
    tests++;
    if (rsp_result !== 32'd120 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL single_val: got %0d err=%0b want 120 err=0", rsp_result, rsp_err);
    end
    req = '0;
    tick;
    tests++;
    if (rsp_valid !== '0) begin
      fails++; $display("FAIL single_pulse: got %b want 00", rsp_valid);
    end
    repeat (3) tick;
    tests++;
    if (gnt !== '0 || core_go !== 1'b0) begin
      fails++; $display("FAIL single_idle: got gnt=%b go=%0b want 00 0", gnt, core_go);
    end
  endtask

  task automatic test_error;
    int idx, gap; bit ok;
    req = 2'b10; req_n[7:4] = 4'd13;
    wait_rsp(idx, gap, ok);
    tests++;
    if (!ok || idx != 1 || rsp_err !== 1'b1 || rsp_result !== '0) begin
      fails++; $display("FAIL err_rsp: got ok=%0b idx=%0d err=%0b res=%0h want 1 1 1 0", ok, idx, rsp_err, rsp_result);
    end
    req = '0;
    repeat (3) tick;
    req = 2'b10; req_n[7:4] = 4'd3;
    wait_rsp(idx, gap, ok);
    tests++;
    if (!ok || idx != 1 || rsp_err !== 1'b0 || rsp_result !== 32'd6) begin
      fails++; $display("FAIL err_recover: got ok=%0b idx=%0d err=%0b res=%0d want 1 1 0 6", ok, idx, rsp_err, rsp_result);
    end
    req = '0;
    repeat (4) tick;
  endtask

  task automatic test_contention;
    int idx, gap; bit ok;
    int exp_idx;
    logic [DW-1:0] exp_res;
    rst = 1'b1; repeat (2) tick; rst = 1'b0;
    req = 2'b11; req_n = {4'd6, 4'd4};
    for (int k = 0; k < 4; k++) begin
      exp_idx = k % 2;
      exp_res = (k % 2 == 1) ? 32'd720 : 32'd24;
      wait_rsp(idx, gap, ok);
      tests++;
      if (!ok || idx != exp_idx || rsp_result !== exp_res) begin
        fails++; $display("FAIL contention_%0d: got ok=%0b idx=%0d res=%0d want idx=%0d res=%0d", k, ok, idx, rsp_result, exp_idx, exp_res);
      end
    end
    req = '0;
    repeat (4) tick;
  endtask

  task automatic test_withdraw;
    int idx, gap; bit ok;
    req = 2'b01; req_n[3:0] = 4'd0;
    tick;
    req = '0;
    wait_rsp(idx, gap, ok);
    tests++;
    if (!ok || idx != 0 || rsp_result !== 32'd1 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL withdraw_n0: got ok=%0b idx=%0d res=%0d err=%0b want 1 0 1 0", ok, idx, rsp_result, rsp_err);
    end
    repeat (4) tick;
    req = 2'b01; req_n[3:0] = 4'd1;
    wait_rsp(idx, gap, ok);
    tests++;
    if (!ok || idx != 0 || rsp_result !== 32'd1) begin
      fails++; $display("FAIL edge_n1: got ok=%0b idx=%0d res=%0d want 1 0 1", ok, idx, rsp_result);
    end
    req = '0;
    repeat (4) tick;
  endtask

  task automatic test_reset_mid;
    int idx, gap; bit ok;
    req = 2'b01; req_n[3:0] = 4'd10;
    repeat (2) tick;
    tests++;
    if (core_go !== 1'b1) begin
      fails++; $display("FAIL rstmid_busy: got go=%0b want 1", core_go);
    end
    rst = 1'b1;
    tick;
    tests++;
    if ({gnt, rsp_valid, core_go, core_n, rsp_err, rsp_result} !== '0) begin
      fails++; $display("FAIL rstmid_clear: got %0h want 0", {gnt, rsp_valid, core_go, core_n, rsp_err, rsp_result});
    end
    rst = 1'b0; req = 2'b10; req_n = {4'd10, 4'd0};
    tick;
    tests++;
    if (gnt !== 2'b10) begin
      fails++; $display("FAIL rstmid_gnt: got %b want 10", gnt);
    end
    wait_rsp(idx, gap, ok);
    tests++;
    if (!ok || idx != 1 || rsp_result !== 32'd3628800) begin
      fails++; $display("FAIL rstmid_res: got ok=%0b idx=%0d res=%0d want 1 1 3628800", ok, idx, rsp_result);
    end
    req = '0;
    repeat (4) tick;
  endtask

`ifdef FACT_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    core_hang = 1'b1;
    req = 2'b01; req_n[3:0] = 4'd2;
    tick;
    cnt = 0;
    while (core_go && cnt < 50) begin
      cnt++;
      tick;
    end
    tests++;
    if (cnt != TMO) begin
      fails++; $display("FAIL tmo_cycles: got %0d want %0d", cnt, TMO);
    end
    tests++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_result !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL tmo_rsp: got v=%b err=%0b res=%0h want 01 1 ffffffff", rsp_valid, rsp_err, rsp_result);
    end
    req = '0; core_hang = 1'b0;
    repeat (4) tick;
    tests++;
    if (gnt !== '0 || core_go !== 1'b0) begin
      fails++; $display("FAIL tmo_idle: got gnt=%b go=%0b want 00 0", gnt, core_go);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_error;
    test_contention;
    test_withdraw;
    test_reset_mid;
`ifdef FACT_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fact_arbiter.md
Name: fact_arbiter

Overview:
Shares one factorial accelerator (go/done/error handshake, n input, result output) between NREQ requesters, e.g. the CPU bus wrapper and a DMA/test port. It uses round-robin arbitration, drives the core's go and n, captures result and error when the core finishes, and returns a one-cycle response pulse to the granted requester. It sits between the requester-side register interfaces and the single factorial core in the SoC.

Parameters:
NREQ, 2, number of requesters (2..8)
IW, 4, width of factorial input n
DW, 32, width of factorial result
TMO_CYCLES, 64, watchdog limit in cycles (used only with FACT_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  NREQ  per-requester request level; hold high with stable n until own rsp_valid
req_n  in  NREQ*IW  packed n per requester; slice i = bits [i*IW +: IW]
gnt  out  NREQ  one-hot, registered; marks the requester currently owning the core
rsp_valid  out  NREQ  one-hot, one-cycle response pulse
rsp_result  out  DW  captured result; held until next capture
rsp_err  out  1  captured error flag; held until next capture
core_go  out  1  go to factorial core, registered
core_n  out  IW  n to factorial core, registered, stable while core_go=1
core_done  in  1  core done (may be combinational)
core_err  in  1  core error (n out of range), qualified by core_done
core_result  in  DW  core result, valid when core_done=1 and core_err=0

Behaviour:
- Reset: state=IDLE; gnt=0, rsp_valid=0, rsp_result=0, rsp_err=0, core_go=0, core_n=0; rr pointer=NREQ-1, so requester 0 wins first.
- States: IDLE, BUSY, RESP, DRAIN.
- IDLE: if any req, pick the first set bit searching from ptr+1 with wrap-around. Next edge: gnt[w]=1, core_n=req_n[w], core_go=1, ptr=w, go to BUSY. No req: stay.
- BUSY: core_go held at 1 and core_n stable. First cycle with core_done=1: capture rsp_result=(core_err?0:core_result) and rsp_err=core_err, drop core_go, then go to RESP. core_done is ignored during the first BUSY cycle only if it was already high at entry (not possible after DRAIN; see below).
- RESP: for exactly one cycle, rsp_valid[w]=1 and core_go=0. Next state is DRAIN if core_done=1, else IDLE. gnt clears on leaving RESP.
- DRAIN: core_go=0; wait for core_done=0, then IDLE. This prevents a stale done from being taken as the next operation's completion.
- Latency: request seen in IDLE at cycle t gives core_go at t+1. Core done at cycle d gives rsp_valid at d+1. Minimum gap between grants: RESP plus optional DRAIN plus IDLE.
- Error path: core raises done+err while go is high with out-of-range n. Same flow; rsp_err=1, rsp_result=0.
- Requester drops req mid-operation: the operation completes and rsp_valid still pulses. The requester may ignore it.
- req still high in the cycle after rsp_valid: treated as a new request; round-robin gives other pending requesters priority first.
- Simultaneous requests: strict rotation; no requester waits more than NREQ-1 operations.
- rst mid-operation: immediate return to reset values; core_go=0 at the next edge. The core is reset by the same rst.

Optional Feature:
FACT_ARB_TIMEOUT_EN
- Defined: BUSY counts cycles. If the count reaches TMO_CYCLES without core_done, drop core_go, set rsp_err=1, rsp_result={DW{1'b1}}, then go to RESP and then DRAIN. The counter clears on each BUSY entry.
- Undefined: no counter; BUSY waits indefinitely.

Test Plan:
- Single op: req[0]=1, n=5 -> core_go next cycle, core_n=5; rsp_valid[0] pulse one cycle after core_done; rsp_result=120, rsp_err=0; gnt returns to 0.
- Out-of-range: req[1]=1, n=13 (core limit 12) -> rsp_valid[1] pulse, rsp_err=1, rsp_result=0; after DRAIN, a new req[1] with n=3 returns 6.
- Contention: req=2'b11 from reset, n0=4, n1=6 -> requester 0 served first (24), then 1 (720); both held high -> grants alternate 0,1,0,1.
- Withdrawal and edge values: req[0] pulsed 1 cycle with n=0 -> op completes, rsp_valid[0] pulses, rsp_result=1; n=1 -> 1.
- Reset mid-BUSY: assert rst during an n=10 op -> next edge all outputs 0; after release, req[1] alone is granted and n=10 returns 3628800.
- Timeout (FACT_ARB_TIMEOUT_EN, TMO_CYCLES=8, core model never raises done) -> core_go drops after 8 BUSY cycles; rsp_err=1, rsp_result=32'hFFFFFFFF.
